// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the cpu_seq program sequencer: branch opcodes and FSM states.
package cpu_seq_pkg;

  localparam logic [2:0] BR_NEXT = 3'd0;
  localparam logic [2:0] BR_JMP  = 3'd1;
  localparam logic [2:0] BR_JZ   = 3'd2;
  localparam logic [2:0] BR_JNZ  = 3'd3;
  localparam logic [2:0] BR_CALL = 3'd4;
  localparam logic [2:0] BR_RET  = 3'd5;
  localparam logic [2:0] BR_JBR  = 3'd6;
  localparam logic [2:0] BR_HALT = 3'd7;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_seq_stack.sv
// Call/return LIFO. Only the occupancy count is reset; entry contents persist.
// The caller never pushes when full or pops when empty, but both are guarded here too.
module cpu_seq_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [IW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign top_idx = IW'(count_q - CW'(1));
  assign top     = mem[top_idx];
  assign count   = count_q;

  // Occupancy moves up on a push and down on a pop.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register, cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage has no reset so it maps onto plain RAM/flops without clear.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[count_q[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cpu_seq.sv
// Program sequencer: fetches over a req/ack handshake, holds the instruction in IR,
// then applies the decoder's branch op to compute the next PC. Supports a call stack,
// base-relative jumps, execute stall, and halt/fault reporting.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int                AWIDTH      = 8,
  parameter int                DWIDTH      = 13,
  parameter int                STACK_DEPTH = 4,
  parameter logic [AWIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  output logic                           IMEM_REQ,
  output logic [AWIDTH-1:0]              IMEM_ADDR,
  input  logic                           IMEM_ACK,
  input  logic [DWIDTH-1:0]              IMEM_DATA,
  output logic [DWIDTH-1:0]              IR,
  output logic                           IR_VALID,
  input  logic [2:0]                     BR_OP,
  input  logic [AWIDTH-1:0]              BR_TARGET,
  input  logic                           BASE_LD,
  input  logic [AWIDTH-1:0]              BASE_DATA,
  input  logic                           Z,
  input  logic                           STALL,
  output logic [AWIDTH-1:0]              PC,
  output logic [$clog2(STACK_DEPTH):0]   SP,
  output logic                           HALTED,
  output logic                           FAULT
);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [DWIDTH-1:0]   ir_q, ir_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic                fault_q, fault_d;
  logic [AWIDTH-1:0]   pc_plus1;
  logic                stk_push;
  logic                stk_pop;
  logic [AWIDTH-1:0]   stk_top;
  logic                stk_full;
  logic                stk_empty;

  assign pc_plus1 = pc_q + AWIDTH'(1);

  cpu_seq_stack #(
    .WIDTH (AWIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_plus1),
    .top   (stk_top),
    .count (SP),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-state, next-PC and stack control; everything holds unless the FSM advances.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    base_d   = base_q;
    fault_d  = fault_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!STALL) begin
          state_d = S_FETCH;
          if (BASE_LD) begin
            base_d = BASE_DATA;
          end
          case (BR_OP)
            BR_NEXT: pc_d = pc_plus1;
            BR_JMP:  pc_d = BR_TARGET;
            BR_JZ:   pc_d = Z ? BR_TARGET : pc_plus1;
            BR_JNZ:  pc_d = Z ? pc_plus1 : BR_TARGET;
            BR_CALL: begin
              if (stk_full) begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                stk_push = 1'b1;
                pc_d     = BR_TARGET;
              end
            end
            BR_RET: begin
              if (stk_empty) begin
                fault_d = 1'b1;
                state_d = S_HALT;
              end else begin
                stk_pop = 1'b1;
                pc_d    = stk_top;
              end
            end
            BR_JBR:  pc_d = base_q + BR_TARGET;
            default: state_d = S_HALT;
          endcase
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Sequencer state registers with asynchronous reset back to BOOT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_ADDR;
      ir_q    <= '0;
      base_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      base_q  <= base_d;
      fault_q <= fault_d;
    end
  end

  assign IMEM_REQ  = (state_q == S_FETCH);
  assign IR_VALID  = (state_q == S_EXEC);
  assign HALTED    = (state_q == S_HALT);
  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Randomized scoreboard bench for cpu_seq: a driver plays instruction memory and decoder,
// updates an abstract program model and queues expected fetch/exec/halt events; a monitor
// pops and compares whenever the DUT starts a fetch, an execute, or halts.
module tb_cpu_seq;

  localparam int AW    = 8;
  localparam int DW    = 13;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RST_ADDR = 8'h00;

  logic           CLK;
  logic           RST_N;
  logic           IMEM_REQ;
  logic [AW-1:0]  IMEM_ADDR;
  logic           IMEM_ACK;
  logic [DW-1:0]  IMEM_DATA;
  logic [DW-1:0]  IR;
  logic           IR_VALID;
  logic [2:0]     BR_OP;
  logic [AW-1:0]  BR_TARGET;
  logic           BASE_LD;
  logic [AW-1:0]  BASE_DATA;
  logic           Z;
  logic           STALL;
  logic [AW-1:0]  PC;
  logic [SPW-1:0] SP;
  logic           HALTED;
  logic           FAULT;

  cpu_seq #(
    .AWIDTH      (AW),
    .DWIDTH      (DW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (RST_ADDR)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_DATA (IMEM_DATA),
    .IR        (IR),
    .IR_VALID  (IR_VALID),
    .BR_OP     (BR_OP),
    .BR_TARGET (BR_TARGET),
    .BASE_LD   (BASE_LD),
    .BASE_DATA (BASE_DATA),
    .Z         (Z),
    .STALL     (STALL),
    .PC        (PC),
    .SP        (SP),
    .HALTED    (HALTED),
    .FAULT     (FAULT)
  );

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {EV_FETCH = 0, EV_EXEC = 1, EV_HALT = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       addr;
    int       data;
    int       sp;
    int       fault;
  } ev_t;
  typedef struct {
    int op;
    int tgt;
    bit ld;
    int bd;
    bit z;
  } instr_t;

  int      total = 0;
  int      bad   = 0;
  ev_t     exp_q[$];
  instr_t  dir_q[$];
  logic [DW-1:0] mem [256];

  int  m_pc;
  int  m_base;
  int  m_stk[$];
  bit  m_halted;
  bit  m_fault;

  bit  started = 1'b0;
  int  wait_cnt;
  bit  prev_req, prev_ack_hs, prev_req_wait, prev_exec_done;
  int  idle;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pop_event(input ev_kind_e k, output ev_t ev, output bit ok);
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected event: got kind %0d, want none queued (t=%0t)", int'(k), $time);
    end else begin
      ev = exp_q.pop_front();
      check_output("event order", int'(k), int'(ev.kind));
      ok = (ev.kind == k);
    end
  endtask

  task automatic push_fetch();
    exp_q.push_back('{EV_FETCH, m_pc, 0, m_stk.size(), int'(m_fault)});
    exp_q.push_back('{EV_EXEC, m_pc, int'(mem[m_pc]), m_stk.size(), int'(m_fault)});
  endtask

  // Abstract program model: one call per completed (non-stalled) instruction.
  task automatic model_exec(input instr_t in);
    int pc1;
    bit halt_now;
    pc1      = (m_pc + 1) % 256;
    halt_now = 1'b0;
    case (in.op)
      0: m_pc = pc1;
      1: m_pc = in.tgt;
      2: m_pc = in.z ? in.tgt : pc1;
      3: m_pc = in.z ? pc1 : in.tgt;
      4: begin
        if (m_stk.size() == DEPTH) begin
          m_fault  = 1'b1;
          halt_now = 1'b1;
        end else begin
          m_stk.push_back(pc1);
          m_pc = in.tgt;
        end
      end
      5: begin
        if (m_stk.size() == 0) begin
          m_fault  = 1'b1;
          halt_now = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
      6: m_pc = (m_base + in.tgt) % 256;
      default: halt_now = 1'b1;
    endcase
    if (in.ld) m_base = in.bd;
    if (halt_now) begin
      m_halted = 1'b1;
      exp_q.push_back('{EV_HALT, m_pc, 0, m_stk.size(), int'(m_fault)});
    end else begin
      push_fetch();
    end
  endtask

  task automatic drive_instr(input instr_t in);
    BR_OP     = 3'(in.op);
    BR_TARGET = AW'(in.tgt);
    BASE_LD   = in.ld;
    BASE_DATA = AW'(in.bd);
    Z         = in.z;
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.op  = int'($urandom_range(0, 7));
    if (r.op == 7 && $urandom_range(0, 15) != 0) r.op = 0;
    r.tgt = int'($urandom_range(0, 255));
    r.ld  = ($urandom_range(0, 3) == 0);
    r.bd  = int'($urandom_range(0, 255));
    r.z   = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // One cycle of memory + decoder behaviour, called just after each falling edge.
  task automatic apply_stimulus();
    instr_t in;
    if (prev_ack_hs) begin
      check_output("exec after ack", int'(IR_VALID), 1);
      check_output("req drop after ack", int'(IMEM_REQ), 0);
    end else if (prev_req_wait) begin
      check_output("req held", int'(IMEM_REQ), 1);
    end
    if (prev_exec_done) begin
      check_output("halted after exec", int'(HALTED), int'(m_halted));
      check_output("fetch after exec", int'(IMEM_REQ), int'(!m_halted));
    end
    prev_ack_hs   = 1'b0;
    prev_req_wait = 1'b0;
    if (IMEM_REQ) begin
      if (!prev_req) wait_cnt = int'($urandom_range(0, 3));
      if (wait_cnt == 0) begin
        IMEM_ACK    = 1'b1;
        IMEM_DATA   = mem[IMEM_ADDR];
        prev_ack_hs = 1'b1;
      end else begin
        IMEM_ACK      = 1'b0;
        IMEM_DATA     = DW'($urandom);
        wait_cnt--;
        prev_req_wait = 1'b1;
      end
    end else begin
      IMEM_ACK  = 1'($urandom_range(0, 1));
      IMEM_DATA = DW'($urandom);
    end
    prev_req       = IMEM_REQ;
    prev_exec_done = 1'b0;
    if (IR_VALID) begin
      idle = 0;
      if ($urandom_range(0, 3) == 0) begin
        STALL = 1'b1;
        drive_instr(rand_instr());
      end else begin
        STALL = 1'b0;
        if (dir_q.size() != 0) in = dir_q.pop_front();
        else in = rand_instr();
        drive_instr(in);
        model_exec(in);
        prev_exec_done = 1'b1;
      end
    end else begin
      STALL = 1'($urandom_range(0, 1));
      drive_instr(rand_instr());
      idle++;
    end
  endtask

  // Asynchronous reset in mid-cycle, reset-value checks, then release on a falling edge.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_output("rst PC", int'(PC), int'(RST_ADDR));
    check_output("rst IMEM_ADDR", int'(IMEM_ADDR), int'(RST_ADDR));
    check_output("rst IMEM_REQ", int'(IMEM_REQ), 0);
    check_output("rst IR", int'(IR), 0);
    check_output("rst IR_VALID", int'(IR_VALID), 0);
    check_output("rst SP", int'(SP), 0);
    check_output("rst HALTED", int'(HALTED), 0);
    check_output("rst FAULT", int'(FAULT), 0);
    started   = 1'b1;
    IMEM_ACK  = 1'b0;
    IMEM_DATA = '0;
    STALL     = 1'b0;
    drive_instr('{0, 0, 1'b0, 0, 1'b0});
    exp_q.delete();
    dir_q.delete();
    m_stk.delete();
    m_pc     = int'(RST_ADDR);
    m_base   = 0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    prev_req = 1'b0; prev_ack_hs = 1'b0; prev_req_wait = 1'b0; prev_exec_done = 1'b0;
    idle     = 0;
    wait_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    push_fetch();
  endtask

  // Monitor: pops an expected event at each fetch start, execute start and halt entry.
  logic mon_req = 1'b0, mon_valid = 1'b0, mon_halt = 1'b0;
  int   cur_addr = -1;
  int   cur_ir   = -1;
  always @(negedge CLK) begin
    ev_t ev;
    bit  ok;
    if (started && RST_N) begin
      if (IMEM_REQ && !mon_req) begin
        pop_event(EV_FETCH, ev, ok);
        if (ok) begin
          cur_addr = ev.addr;
          check_output("fetch SP", int'(SP), ev.sp);
          check_output("fetch FAULT", int'(FAULT), ev.fault);
        end
      end
      if (IMEM_REQ) check_output("fetch addr", int'(IMEM_ADDR), cur_addr);
      if (IR_VALID && !mon_valid) begin
        pop_event(EV_EXEC, ev, ok);
        if (ok) cur_ir = ev.data;
      end
      if (IR_VALID) begin
        check_output("exec IR", int'(IR), cur_ir);
        check_output("exec PC", int'(PC), cur_addr);
      end
      if (HALTED && !mon_halt) begin
        pop_event(EV_HALT, ev, ok);
        if (ok) begin
          check_output("halt PC", int'(PC), ev.addr);
          check_output("halt SP", int'(SP), ev.sp);
          check_output("halt FAULT", int'(FAULT), ev.fault);
        end
      end
      if (HALTED) check_output("halt no req", int'(IMEM_REQ), 0);
      mon_req   = IMEM_REQ;
      mon_valid = IR_VALID;
      mon_halt  = HALTED;
    end else begin
      mon_req   = 1'b0;
      mon_valid = 1'b0;
      mon_halt  = 1'b0;
    end
  end

  // Main sequence: two directed programs, then random episodes, some aborted by reset.
  initial begin
    int cycles;
    int post_halt;
    int abort_at;
    RST_N     = 1'b1;
    IMEM_ACK  = 1'b0;
    IMEM_DATA = '0;
    STALL     = 1'b0;
    BR_OP     = '0;
    BR_TARGET = '0;
    BASE_LD   = 1'b0;
    BASE_DATA = '0;
    Z         = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      if (ep == 0) begin
        dir_q.push_back('{0, 8'h00, 1'b0, 0, 1'b0});
        dir_q.push_back('{0, 8'h00, 1'b0, 0, 1'b0});
        dir_q.push_back('{0, 8'h00, 1'b0, 0, 1'b0});
        dir_q.push_back('{1, 8'h10, 1'b0, 0, 1'b0});
        dir_q.push_back('{4, 8'h40, 1'b0, 0, 1'b0});
        dir_q.push_back('{5, 8'h00, 1'b0, 0, 1'b0});
        dir_q.push_back('{6, 8'h20, 1'b1, 8'hF0, 1'b0});
        dir_q.push_back('{6, 8'h20, 1'b0, 0, 1'b0});
        dir_q.push_back('{1, 8'hFF, 1'b0, 0, 1'b0});
        dir_q.push_back('{0, 8'h00, 1'b0, 0, 1'b0});
        dir_q.push_back('{2, 8'h33, 1'b0, 0, 1'b1});
        dir_q.push_back('{3, 8'h44, 1'b0, 0, 1'b1});
        dir_q.push_back('{5, 8'h00, 1'b0, 0, 1'b0});
      end else if (ep == 1) begin
        dir_q.push_back('{4, 8'h20, 1'b0, 0, 1'b0});
        dir_q.push_back('{4, 8'h30, 1'b0, 0, 1'b0});
        dir_q.push_back('{4, 8'h40, 1'b0, 0, 1'b0});
        dir_q.push_back('{4, 8'h50, 1'b0, 0, 1'b0});
        dir_q.push_back('{4, 8'h60, 1'b0, 0, 1'b0});
      end
      cycles    = 0;
      post_halt = 0;
      abort_at  = (ep % 4 == 3) ? int'($urandom_range(3, 40)) : 300;
      forever begin
        @(negedge CLK);
        apply_stimulus();
        cycles++;
        if (m_halted) post_halt++;
        if (post_halt > 4) break;
        if (cycles >= abort_at) break;
        if (idle > 12 && !m_halted) begin
          check_output("watchdog idle cycles", idle, 0);
          break;
        end
      end
    end
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #2000000;
    total++;
    bad++;
    $display("[TB] FAIL global timeout: got still running, want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_seq.md
# cpu_seq

Parametrised program sequencer for the one-cycle CPU family. It replaces the fixed PC/ROM/jump/single link-register arrangement with four changes:
- instruction fetch over a req/ack handshake to an instruction memory of any latency;
- a call/return stack of configurable depth;
- base-relative jumps;
- an execute-stall input, plus halt and fault reporting.

It sits between the instruction memory and the instruction decoder. The decoder returns the branch control for the instruction held in IR.

## Interface
Parameters:
- AWIDTH, 8, program address width
- DWIDTH, 13, instruction width
- STACK_DEPTH, 4, call-stack entries (power of two, ≥2)
- RESET_ADDR, 0, PC value after reset

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IMEM_REQ  out  1  fetch request
- IMEM_ADDR  out  AWIDTH  fetch address (= PC)
- IMEM_ACK  in  1  fetch data valid
- IMEM_DATA  in  DWIDTH  fetched instruction
- IR  out  DWIDTH  instruction register
- IR_VALID  out  1  execute strobe; IR is valid for the decoder
- BR_OP  in  3  branch op from decoder: 0 NEXT, 1 JMP, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 JBR, 7 HALT
- BR_TARGET  in  AWIDTH  absolute target, or offset for JBR
- BASE_LD  in  1  load base register
- BASE_DATA  in  AWIDTH  base register data
- Z  in  1  ALU zero flag
- STALL  in  1  hold execute stage
- PC  out  AWIDTH  program counter
- SP  out  $clog2(STACK_DEPTH)+1  stack occupancy
- HALTED  out  1  sequencer stopped
- FAULT  out  1  stack overflow/underflow occurred

## Operation
State machine: BOOT → FETCH → EXEC → FETCH …, plus HALT. BOOT is the reset state.

- **BOOT:** all outputs idle. Unconditionally goes to FETCH on the next clock.
- **FETCH:** IMEM_REQ=1, IMEM_ADDR=PC. On IMEM_ACK: IR ← IMEM_DATA, go to EXEC.
- **EXEC:** IR_VALID=1. BR_OP, BR_TARGET, BASE_LD, BASE_DATA and Z are sampled here.
  - STALL=1: remain in EXEC; IR, PC, SP and base unchanged.
  - STALL=0: PC ← next PC, go to FETCH (or HALT).
- **HALT:** HALTED=1, IMEM_REQ=0. Exit only by reset.

Next PC (all additions modulo 2^AWIDTH, PC+1 wraps to 0):
- NEXT: PC+1.
- JMP: BR_TARGET.
- JZ: BR_TARGET if Z else PC+1.
- JNZ: BR_TARGET if !Z else PC+1.
- CALL: push PC+1, then PC ← BR_TARGET.
  - If SP==STACK_DEPTH: no push, FAULT←1, go to HALT, PC unchanged.
- RET: PC ← top of stack, pop.
  - If SP==0: FAULT←1, go to HALT, PC unchanged.
- JBR: PC ← base + BR_TARGET, using the base value *before* any same-cycle BASE_LD.
- HALT: go to HALT, PC unchanged.

Base register:
- BASE_LD is honoured only on a non-stalled EXEC cycle; it updates base at that edge.
- BASE_LD is combinable with any BR_OP.

Stack:
- LIFO. SP counts valid entries, 0..STACK_DEPTH.
- Contents are not cleared by reset; only SP is.

Once FAULT is set it stays set until reset.

## Timing
Reset values: PC=RESET_ADDR, IMEM_ADDR=RESET_ADDR, IMEM_REQ=0, IR=0, IR_VALID=0, SP=0, base=0, HALTED=0, FAULT=0. Reset acts immediately (asynchronously).

Fetch handshake:
- IMEM_REQ is asserted in the cycle after reset release + 1, i.e. after BOOT.
- While IMEM_REQ=1, IMEM_REQ and IMEM_ADDR are held stable until the cycle in which IMEM_ACK=1.
- IMEM_ACK is ignored outside FETCH.
- ACK in the first FETCH cycle is legal (zero wait). IR_VALID is high in the cycle after the ACK edge.

Throughput and latency:
- Minimum instruction period is 2 cycles (FETCH + EXEC). Each wait cycle adds 1; each STALL cycle adds 1.
- PC, SP, base and FAULT update on the edge that ends a non-stalled EXEC.
- The new IMEM_ADDR is visible in the following FETCH cycle.

Reset mid-fetch or mid-stall aborts the operation; state returns to BOOT.

Outputs IMEM_REQ, IR_VALID and HALTED are decoded from registered state only. They have no combinational path from any input.

## Structure
Package cpu_seq_pkg holds:
- BR_OP localparams (BR_NEXT … BR_HALT);
- state encoding (S_BOOT, S_FETCH, S_EXEC, S_HALT).

One sub-module, cpu_seq_stack: parametrised LIFO (WIDTH, DEPTH).
- Inputs: push, pop, data in.
- Outputs: top, count, full, empty.
- Same CLK/RST_N.

Next-PC mux and FSM live in cpu_seq.

## Test plan
- Zero-wait memory, program NEXT×3 from RESET_ADDR=0 → IMEM_ADDR 0,1,2,3 on successive FETCH cycles; IR_VALID every second cycle.
- ACK delayed 3 cycles at address 5 → IMEM_REQ and IMEM_ADDR=5 held 4 cycles; IR loaded on the ACK edge; IR_VALID one cycle later.
- CALL 0x40 at PC 0x10, then RET at 0x40 → SP 0→1→0; fetch addresses 0x40 then 0x11.
- STACK_DEPTH=4, five nested CALLs → fifth: FAULT=1, HALTED=1, SP=4, PC stays at the fifth CALL's address. Separately, RET with SP=0 → FAULT=1, HALTED=1.
- Base-relative and PC wrap:
  - BASE_LD with BASE_DATA=0xF0 plus JBR offset 0x20 in the same cycle → target uses old base (0) → PC=0x20.
  - Next JBR offset 0x20 → PC=0x10 (wrap).
  - NEXT at PC=0xFF → PC=0x00.
- STALL=1 for 3 cycles during a JZ with Z toggling → PC unchanged during stall; branch decided on Z in the release cycle. RST_N low mid-fetch → IMEM_REQ drops immediately; PC=RESET_ADDR.
